// File: rtl/relu_grad_seq.sv
// -----------------------------------------------------------------------------
// relu_grad_seq
//
// Purpose:
//   Sequences the ReLU-derivative gating step of backpropagation over one
//   layer vector of NUM elements. Each accepted (z, err) pair produces
//   grad = (err * relu'(z)) >>> FRAC. The result is held in a one-deep output
//   register until the consumer takes it. A start/busy/done FSM brackets each
//   vector.
//
// Build option:
//   RELU_GRAD_LEAKY_EN  - when defined, the derivative for z < 0 is the leaky
//                         slope 1/8 instead of 0. Timing and handshakes are
//                         the same in both builds.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_start      1-cycle request to process one vector (ignored unless IDLE)
//   o_busy       high from start acceptance until done
//   o_done       1-cycle pulse after the last element leaves
//   i_in_valid   z/err pair valid
//   o_in_ready   block accepts a pair this cycle
//   i_in_z       pre-activation value (Q8.8 signed)
//   i_in_err     upstream error (Q8.8 signed)
//   o_out_valid  grad valid
//   i_out_ready  consumer accepts grad
//   o_out_grad   gated gradient (Q8.8 signed)
//   o_out_last   high with the final element (index NUM-1)
// -----------------------------------------------------------------------------
// state   | meaning
// --------+--------------------------------------------------------------------
// S_IDLE  | waiting for i_start; input closed
// S_RUN   | accepting pairs until NUM have been taken
// S_DRAIN | all inputs taken; waiting for the final output handshake
// S_DONE  | one-cycle done pulse, busy low, then back to S_IDLE
// -----------------------------------------------------------------------------
module relu_grad_seq #(
    parameter int NBITS = 16,
    parameter int FRAC  = 8,
    parameter int NUM   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [NBITS-1:0] i_in_z,
    input  logic [NBITS-1:0] i_in_err,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [NBITS-1:0] o_out_grad,
    output logic             o_out_last
);

    localparam int CW = $clog2(NUM + 1);
    localparam logic [CW-1:0] NUM_C  = CW'(NUM);
    localparam logic [CW-1:0] LAST_C = CW'(NUM - 1);
    localparam int PW = 2 * NBITS;

    // Derivative values in the same Q format as the data: "one" is 1<<FRAC.
    localparam logic signed [PW-1:0] POS_DERIV = PW'(1) << FRAC;
`ifdef RELU_GRAD_LEAKY_EN
    // Slope 1/8: (err * (1<<(FRAC-3))) >>> FRAC is exactly err >>> 3.
    localparam logic signed [PW-1:0] NEG_DERIV = PW'(1) << (FRAC - 3);
`else
    localparam logic signed [PW-1:0] NEG_DERIV = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_in_cnt;
    logic [CW-1:0]       r_out_cnt;
    logic                r_out_valid;
    logic                r_out_last;
    logic [NBITS-1:0]    r_out_grad;

    logic                w_in_ready;
    logic                w_in_hs;
    logic                w_out_hs;
    logic                w_clr_cnt;
    logic                w_busy;
    logic                w_done;
    logic signed [PW-1:0] w_deriv;
    logic signed [PW-1:0] w_err_ext;
    logic signed [PW-1:0] w_prod;
    logic [NBITS-1:0]    w_grad;

    // -------------------------------------------------------------------------
    // Arithmetic. Written as the reference product form; with constant
    // derivative values this reduces to a mux/shift in synthesis.
    // -------------------------------------------------------------------------
    assign w_deriv   = i_in_z[NBITS-1] ? NEG_DERIV : POS_DERIV;
    assign w_err_ext = {{NBITS{i_in_err[NBITS-1]}}, i_in_err};
    assign w_prod    = w_err_ext * w_deriv;
    assign w_grad    = NBITS'(w_prod >>> FRAC);

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign w_in_hs  = i_in_valid && w_in_ready;
    assign w_out_hs = r_out_valid && i_out_ready;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_in_ready  = 1'b0;
        w_clr_cnt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_clr_cnt   = 1'b1;
                end
            end

            S_RUN: begin
                w_busy = 1'b1;
                // A new pair may enter when the output slot is empty or is
                // being emptied this same cycle (full throughput).
                w_in_ready = (r_in_cnt < NUM_C) && (!r_out_valid || i_out_ready);
                if (i_in_valid && w_in_ready && (r_in_cnt == LAST_C)) begin
                    w_state_nxt = S_DRAIN;
                end
            end

            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_out_valid && i_out_ready && (r_out_cnt == LAST_C)) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Counters and the one-deep output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_grad  <= '0;
        end else begin
            if (w_clr_cnt) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end

            if (w_in_hs) begin
                r_out_grad  <= w_grad;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_in_cnt == LAST_C);
                r_in_cnt    <= r_in_cnt + CW'(1);
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + CW'(1);
            end
        end
    end

    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_grad  = r_out_grad;
    assign o_out_last  = r_out_last;

endmodule

// File: doc/relu_grad_seq.md
Name: relu_grad_seq

Overview:
- Sequences the ReLU-derivative gating step of backpropagation over one layer vector of NUM elements.
- Per element, takes pre-activation z and upstream error err (Q8.8 signed, 256 = 1.0) and forms grad = err * relu'(z) >>> FRAC.
- Uses valid/ready streams with a one-deep output register, an element counter and a start/busy/done control FSM.
- Sits between the error-propagation datapath and the weight-update unit.

Parameters:
- NBITS, 16, width of z, err and grad (two's complement).
- FRAC, 8, fractional bits; derivative "one" = 1<<FRAC (256).
- NUM, 8, elements per layer vector (1..255).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  1-cycle request to process one vector
- busy  output  1  high from start acceptance until done
- done  output  1  1-cycle pulse after the last element leaves
- in_valid  input  1  z/err pair valid
- in_ready  output  1  block accepts pair this cycle
- in_z  input  NBITS  pre-activation value
- in_err  input  NBITS  upstream error
- out_valid  output  1  grad valid
- out_ready  input  1  consumer accepts grad
- out_grad  output  NBITS  gated gradient
- out_last  output  1  high with the final element (index NUM-1)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, in_ready=0, out_valid=0, out_grad=0, out_last=0, counters=0. Reset mid-vector discards all in-flight data; no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN next cycle; busy=1 from that cycle; in_cnt=0, out_cnt=0.
  - in_ready=0 in IDLE.
- RUN:
  - in_ready = (in_cnt<NUM) && (!out_valid || out_ready).
  - Input handshake (in_valid && in_ready): register grad into the output register, set out_valid=1, increment in_cnt.
  - out_last=1 when in_cnt was NUM-1.
  - When in_cnt reaches NUM -> DRAIN.
- DRAIN: in_ready=0; wait for the final output handshake.
- Output handshake (out_valid && out_ready):
  - Increment out_cnt.
  - Clear out_valid unless a new input is accepted in the same cycle; simultaneous accept and drain gives full throughput of 1 element/cycle.
  - Output holds stable while out_valid && !out_ready.
- DONE: entered on the handshake of the element with out_last=1. done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
- start while busy, or in DONE, is ignored.
- Latency: 1 cycle from input handshake to out_valid.
- Arithmetic:
  - deriv = z[NBITS-1] ? 0 : (1<<FRAC). z=0 counts as positive (deriv=1.0).
  - Product err*deriv is 2*NBITS wide signed; result = product >>> FRAC, truncated to NBITS.
  - This is exactly err when z>=0 and 0 when z<0; no saturation is needed.
  - Implementation may use a mux instead of a multiplier provided results are bit-identical.

Optional Feature:
- Macro: RELU_GRAD_LEAKY_EN.
- Defined: leaky derivative; for z<0, grad = err >>> 3 (arithmetic, slope 1/8 = 32 in Q8.8); z>=0 is unchanged.
- Undefined: plain ReLU; grad=0 for z<0.
- Timing and handshakes are identical in both builds.

Test Plan:
- Reset then start, NUM=8 pairs with out_ready=1:
  - z alternates 0x0100 / 0xFF00, err=0x0080.
  - Expect grads 0x0080, 0x0000, repeating; out_last on element 8; done pulse one cycle after the last handshake; busy low in that cycle.
- Boundary z values:
  - z=0x0000, err=0xFE00 -> grad 0xFE00.
  - z=0x8000, err=0x7FFF -> grad 0x0000.
  - With RELU_GRAD_LEAKY_EN: z=0x8000, err=0xFE00 -> grad 0xFFC0.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid high -> out_grad stable, in_ready=0, no element lost or duplicated; all 8 outputs delivered in order.
- Full throughput: in_valid=1 and out_ready=1 continuously -> one grad per cycle, 8 consecutive outputs, done at cycle 10 after start.
- start pulsed during RUN and during DONE -> ignored; exactly one done per accepted start; next start from IDLE restarts counts at 0.
- Deassert rst_n after 3 of 8 elements -> all outputs 0 immediately; no done; a fresh start processes a full 8 elements.
